demux_striper_1xn: RTL

- Byte-stream lane demultiplexer.
- Consumes the 8-bit valid/data symbol stream produced by the demux stimulus generator. That stream carries the K-symbols COM, SKP, STP, SDP, END and IDL.
- Aligns the stream on COM, stripes bytes round-robin across LANES output lanes, drops SKP and pads partial words with IDL.
- Feeds the per-lane receive logic downstream.

---
 rtl/demux_striper_1xn.sv | 134 +++++++++++++
 1 files changed

// File: rtl/demux_striper_1xn.sv
// Byte-stream lane demultiplexer: locks on COM, stripes symbols round-robin across
// LANES lanes, drops SKP (counting them) and pads short words with IDL.
module demux_striper_1xn #(
    parameter int          LANES = 4,
    parameter logic [7:0]  COM   = 8'hbc,
    parameter logic [7:0]  SKP   = 8'h1c,
    parameter logic [7:0]  END   = 8'hfd,
    parameter logic [7:0]  IDL   = 8'h7c
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [7:0]           data_in,
    output logic [8*LANES-1:0]   lane_data,
    output logic                 lane_valid,
    output logic [LANES-1:0]     lane_pad,
    output logic                 aligned,
    output logic [7:0]           skp_count
);

    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        STRIPE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           buf_q [LANES];
    logic [7:0]           buf_d [LANES];
    logic [8*LANES-1:0]   lane_data_q, lane_data_d;
    logic [LANES-1:0]     lane_pad_q, lane_pad_d;
    logic                 lane_valid_q, lane_valid_d;
    logic [7:0]           skp_count_q, skp_count_d;

    // Candidate output word if the current symbol closes the word. A COM closes the
    // word without occupying it, so its own lane becomes padding too.
    logic [8*LANES-1:0]   word_flat;
    logic [LANES-1:0]     word_pad;
    logic                 flush_com;

    assign flush_com = (data_in == COM);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [PTR_W-1:0] LANE_IDX = PTR_W'(gi);
            logic held;
            logic cur;
            assign held = (LANE_IDX < ptr_q);
            assign cur  = (LANE_IDX == ptr_q) && !flush_com;
            assign word_flat[8*gi +: 8] = held ? buf_q[gi] : (cur ? data_in : IDL);
            assign word_pad[gi]         = !(held || cur);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        buf_d        = buf_q;
        lane_data_d  = lane_data_q;
        lane_pad_d   = lane_pad_q;
        lane_valid_d = 1'b0;
        skp_count_d  = skp_count_q;

        if (valid_in) begin
            if (state_q == HUNT) begin
                if (data_in == COM) begin
                    buf_d[0] = COM;
                    ptr_d    = PTR_W'(1);
                    state_d  = STRIPE;
                end
            end else if (data_in == SKP) begin
                if (skp_count_q != 8'hff) begin
                    skp_count_d = skp_count_q + 8'd1;
                end
            end else if (data_in == END) begin
                lane_data_d  = word_flat;
                lane_pad_d   = word_pad;
                lane_valid_d = 1'b1;
                ptr_d        = '0;
            end else if ((data_in == COM) && (ptr_q != '0)) begin
                lane_data_d  = word_flat;
                lane_pad_d   = word_pad;
                lane_valid_d = 1'b1;
                buf_d[0]     = COM;
                ptr_d        = PTR_W'(1);
            end else begin
                buf_d[ptr_q] = data_in;
                if (ptr_q == LAST_LANE) begin
                    lane_data_d  = word_flat;
                    lane_pad_d   = word_pad;
                    lane_valid_d = 1'b1;
                    ptr_d        = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            ptr_q        <= '0;
            lane_data_q  <= '0;
            lane_pad_q   <= '0;
            lane_valid_q <= 1'b0;
            skp_count_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lane_data_q  <= lane_data_d;
            lane_pad_q   <= lane_pad_d;
            lane_valid_q <= lane_valid_d;
            skp_count_q  <= skp_count_d;
            for (int k = 0; k < LANES; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign lane_data  = lane_data_q;
    assign lane_pad   = lane_pad_q;
    assign lane_valid = lane_valid_q;
    assign aligned    = (state_q == STRIPE);
    assign skp_count  = skp_count_q;

endmodule
